// File: rtl/sys_defs.sv
// Shared front-end types and constants: instruction word, fetch-buffer entry
// and the fetch-buffer-to-decoder payload.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define NUM_SUPER 2
`define FB_DEPTH  8
`define NOOP_INST 32'h47ff041f

package sys_defs;

    localparam int unsigned NUM_SUPER = `NUM_SUPER;
    localparam int unsigned FB_DEPTH  = `FB_DEPTH;

    typedef logic [31:0] INST_t;

    typedef struct packed {
        INST_t       inst;
        logic [63:0] PC;
        logic [63:0] NPC;
        logic [63:0] target;
    } FB_ENTRY_t;

    typedef struct packed {
        logic                         valid;
        INST_t [NUM_SUPER-1:0]        inst;
        logic  [NUM_SUPER-1:0][63:0]  PC;
        logic  [NUM_SUPER-1:0][63:0]  NPC;
        logic  [NUM_SUPER-1:0][63:0]  target;
    } FB_DECODER_OUT_t;

endpackage

`endif

// File: rtl/fetch_buffer.sv
// In-order circular queue between fetch and decode; pushes and pops whole
// instruction pairs and presents the oldest pair show-ahead.
module fetch_buffer
    import sys_defs::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         if_valid,
    input  INST_t [NUM_SUPER-1:0]        if_inst,
    input  logic  [NUM_SUPER-1:0][63:0]  if_PC,
    input  logic  [NUM_SUPER-1:0][63:0]  if_NPC,
    input  logic  [NUM_SUPER-1:0][63:0]  if_target,
    input  logic                         dispatch_en,
    input  logic                         rollback_en,
    output logic                         fb_ready,
    output FB_DECODER_OUT_t              FB_decoder_out
);

    localparam int unsigned PTR_W = $clog2(FB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam FB_ENTRY_t   RESET_ENTRY = '{inst: `NOOP_INST, PC: '0, NPC: '0, target: '0};

    FB_ENTRY_t [FB_DEPTH-1:0]        entries_q;
    logic [PTR_W-1:0]                head_q, head_d;
    logic [PTR_W-1:0]                tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [NUM_SUPER-1:0][PTR_W-1:0] wr_idx;
    logic [NUM_SUPER-1:0][PTR_W-1:0] rd_idx;
    logic                            out_valid;
    logic                            push;
    logic                            pop;

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign fb_ready  = (count_q <= CNT_W'(FB_DEPTH - NUM_SUPER));
    assign out_valid = (count_q >= CNT_W'(NUM_SUPER));
    assign push      = if_valid & fb_ready & ~rollback_en;
    assign pop       = out_valid & dispatch_en & ~rollback_en;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < NUM_SUPER; i++) begin
            wr_idx[i] = tail_q + PTR_W'(i);
            rd_idx[i] = head_q + PTR_W'(i);
        end
        if (rollback_en) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d  = tail_q + PTR_W'(NUM_SUPER);
                count_d = count_d + CNT_W'(NUM_SUPER);
            end
            if (pop) begin
                head_d  = head_q + PTR_W'(NUM_SUPER);
                count_d = count_d - CNT_W'(NUM_SUPER);
            end
        end
    end

    // Head pair straight from storage; stale fields are masked by valid downstream.
    always_comb begin
        FB_decoder_out       = '0;
        FB_decoder_out.valid = out_valid;
        for (int i = 0; i < NUM_SUPER; i++) begin
            FB_decoder_out.inst[i]   = entries_q[rd_idx[i]].inst;
            FB_decoder_out.PC[i]     = entries_q[rd_idx[i]].PC;
            FB_decoder_out.NPC[i]    = entries_q[rd_idx[i]].NPC;
            FB_decoder_out.target[i] = entries_q[rd_idx[i]].target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= {FB_DEPTH{RESET_ENTRY}};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                for (int i = 0; i < NUM_SUPER; i++) begin
                    entries_q[wr_idx[i]] <= '{inst:   if_inst[i],
                                              PC:     if_PC[i],
                                              NPC:    if_NPC[i],
                                              target: if_target[i]};
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Occupancy must stay even and within [0, FB_DEPTH].
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (count_q <= CNT_W'(FB_DEPTH))
                else $error("fetch_buffer: count above depth");
            assert (count_q[0] == 1'b0)
                else $error("fetch_buffer: odd count");
            assert (!(push && !pop && count_q > CNT_W'(FB_DEPTH - NUM_SUPER)))
                else $error("fetch_buffer: overflow");
            assert (!(pop && !push && count_q < CNT_W'(NUM_SUPER)))
                else $error("fetch_buffer: underflow");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: ordering, full/empty gating, rollback and
// asynchronous reset, with hand-computed expected head contents.
module tb_fetch_buffer;
    import sys_defs::*;

    localparam INST_t ADDQ = 32'h40010402;
    localparam INST_t BR   = 32'hc3e00000;
    localparam INST_t NOOP = `NOOP_INST;

    logic                         clock;
    logic                         reset;
    logic                         if_valid;
    INST_t [NUM_SUPER-1:0]        if_inst;
    logic  [NUM_SUPER-1:0][63:0]  if_PC;
    logic  [NUM_SUPER-1:0][63:0]  if_NPC;
    logic  [NUM_SUPER-1:0][63:0]  if_target;
    logic                         dispatch_en;
    logic                         rollback_en;
    logic                         fb_ready;
    FB_DECODER_OUT_t              fb_out;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_PC          (if_PC),
        .if_NPC         (if_NPC),
        .if_target      (if_target),
        .dispatch_en    (dispatch_en),
        .rollback_en    (rollback_en),
        .fb_ready       (fb_ready),
        .FB_decoder_out (fb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pair at pc: slot i has PC=pc+4i, NPC=pc+4i+4, target=pc+0x100+4i.
    task automatic drive_pair(input logic [63:0] pc);
        if_valid = 1'b1;
        for (int i = 0; i < NUM_SUPER; i++) begin
            if_inst[i]   = ((i == 0) ? ADDQ : BR) ^ 32'(pc);
            if_PC[i]     = pc + 64'(4 * i);
            if_NPC[i]    = pc + 64'(4 * i + 4);
            if_target[i] = pc + 64'h100 + 64'(4 * i);
        end
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc);
        check({tag, ".valid"}, 64'(fb_out.valid), 64'd1);
        check({tag, ".pc0"},   fb_out.PC[0],      pc);
        check({tag, ".pc1"},   fb_out.PC[1],      pc + 64'd4);
        check({tag, ".npc0"},  fb_out.NPC[0],     pc + 64'd4);
        check({tag, ".inst0"}, 64'(fb_out.inst[0]), 64'(ADDQ ^ 32'(pc)));
        check({tag, ".inst1"}, 64'(fb_out.inst[1]), 64'(BR ^ 32'(pc)));
        check({tag, ".tgt1"},  fb_out.target[1],  pc + 64'h104);
    endtask

    initial begin
        reset       = 1'b1;
        if_valid    = 1'b0;
        dispatch_en = 1'b0;
        rollback_en = 1'b0;
        if_inst     = '0;
        if_PC       = '0;
        if_NPC      = '0;
        if_target   = '0;

        #2 reset = 1'b0;
        tick();
        tick();
        check("rst.valid", 64'(fb_out.valid), 64'd0);
        check("rst.ready", 64'(fb_ready), 64'd1);
        check("rst.count", 64'(dut.count_q), 64'd0);
        check("rst.noop",  64'(fb_out.inst[0]), 64'(NOOP));
        reset = 1'b1;

        // First pair visible one cycle after push
        drive_pair(64'h0);
        tick();
        if_valid = 1'b0;
        check_head("push1", 64'h0);
        check("push1.ready", 64'(fb_ready), 64'd1);
        check("push1.count", 64'(dut.count_q), 64'd2);

        // Fill to full, then a dropped pair
        for (int k = 1; k < 4; k++) begin
            drive_pair(64'(8 * k));
            tick();
        end
        if_valid = 1'b0;
        check("full.ready", 64'(fb_ready), 64'd0);
        check("full.count", 64'(dut.count_q), 64'd8);
        drive_pair(64'h20);
        tick();
        if_valid = 1'b0;
        check("drop.count", 64'(dut.count_q), 64'd8);
        check_head("drop.head", 64'h0);

        // Drain in order
        dispatch_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("drain%0d", k), 64'(8 * k));
            tick();
        end
        dispatch_en = 1'b0;
        check("drain.valid", 64'(fb_out.valid), 64'd0);
        check("drain.ready", 64'(fb_ready), 64'd1);
        check("drain.count", 64'(dut.count_q), 64'd0);

        // Full with push+pop: push gated, pop proceeds
        for (int k = 0; k < 4; k++) begin
            drive_pair(64'h40 + 64'(8 * k));
            tick();
        end
        check("refill.ready", 64'(fb_ready), 64'd0);
        drive_pair(64'h60);
        dispatch_en = 1'b1;
        tick();
        if_valid    = 1'b0;
        dispatch_en = 1'b0;
        check_head("fullpp", 64'h48);
        check("fullpp.count", 64'(dut.count_q), 64'd6);
        check("fullpp.ready", 64'(fb_ready), 64'd1);

        // Push+pop below full: count unchanged
        drive_pair(64'h60);
        dispatch_en = 1'b1;
        tick();
        if_valid    = 1'b0;
        dispatch_en = 1'b0;
        check_head("pp6", 64'h50);
        check("pp6.count", 64'(dut.count_q), 64'd6);

        // Rollback with 3 pairs buffered and a push offered
        rollback_en = 1'b1;
        dispatch_en = 1'b1;
        drive_pair(64'h80);
        tick();
        rollback_en = 1'b0;
        dispatch_en = 1'b0;
        if_valid    = 1'b0;
        check("rb.valid", 64'(fb_out.valid), 64'd0);
        check("rb.count", 64'(dut.count_q), 64'd0);
        check("rb.ready", 64'(fb_ready), 64'd1);
        drive_pair(64'h100);
        tick();
        if_valid = 1'b0;
        check_head("rb.new", 64'h100);
        check("rb.new.count", 64'(dut.count_q), 64'd2);
        dispatch_en = 1'b1;
        tick();
        dispatch_en = 1'b0;
        check("rb.empty", 64'(fb_out.valid), 64'd0);

        // Continuous push+pop of 10 pairs across pointer wraps
        dispatch_en = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k >= 1) begin
                check_head($sformatf("strm%0d", k - 1), 64'(8 * (k - 1)));
                check($sformatf("strm%0d.count", k - 1), 64'(dut.count_q), 64'd2);
            end
            if (k < 10) drive_pair(64'(8 * k));
            else        if_valid = 1'b0;
            tick();
        end
        dispatch_en = 1'b0;
        check("strm.valid", 64'(fb_out.valid), 64'd0);
        check("strm.count", 64'(dut.count_q), 64'd0);

        // Asynchronous reset mid-stream with count=6
        for (int k = 0; k < 3; k++) begin
            drive_pair(64'h200 + 64'(8 * k));
            tick();
        end
        check("mid.count", 64'(dut.count_q), 64'd6);
        drive_pair(64'h218);
        reset    = 1'b0;
        if_valid = 1'b0;
        #1;
        check("arst.valid", 64'(fb_out.valid), 64'd0);
        check("arst.ready", 64'(fb_ready), 64'd1);
        check("arst.count", 64'(dut.count_q), 64'd0);
        check("arst.noop",  64'(fb_out.inst[0]), 64'(NOOP));
        #3 reset = 1'b1;
        tick();
        drive_pair(64'h40);
        tick();
        if_valid = 1'b0;
        check_head("post", 64'h40);
        check("post.head", 64'(dut.head_q), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
